// File: rtl/sc_speedtimer_pkg.sv
// sc_speedtimer_pkg: shared state encoding and level-to-period function for the speed timers
package sc_speedtimer_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, COUNT = 2'd2, PAUSE = 2'd3} state_t;
    function automatic logic [63:0] period(input logic [63:0] base, step, floor, level);
        return (level * step + floor > base) ? floor : base - level * step;
    endfunction
endpackage

// File: rtl/sc_falledge_detect.sv
// sc_falledge_detect: registered falling-edge detector, one-cycle pulse per 1->0 transition
module sc_falledge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic fall
);
    logic cur, prev;
    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= 1'b0;
            prev <= 1'b0;
        end else begin
            cur <= sig;
            prev <= cur;
        end
    end
    assign fall = prev & ~cur;
endmodule

// File: rtl/sc_downspeedtimer.sv
// sc_downspeedtimer: level-programmable down-counting period timer emitting one-cycle ticks
module sc_downspeedtimer
    import sc_speedtimer_pkg::*;
#(
    parameter int DATAWIDTH   = 23,
    parameter int LEVELWIDTH  = 3,
    parameter int BASE_PERIOD = 5_000_000,
    parameter int STEP_PERIOD = 500_000,
    parameter int MIN_PERIOD  = 1_000_000
) (
    input  logic                  SC_downSPEEDTIMER_CLOCK_50,
    input  logic                  SC_downSPEEDTIMER_RESET_InHigh,
    input  logic                  SC_downSPEEDTIMER_start_InLow,
    input  logic                  SC_downSPEEDTIMER_pause_InLow,
    input  logic                  SC_downSPEEDTIMER_levelup_InLow,
    input  logic                  SC_downSPEEDTIMER_CLEAR_InLow,
    output logic                  SC_downSPEEDTIMER_tick_Out,
    output logic                  SC_downSPEEDTIMER_running_Out,
    output logic [DATAWIDTH-1:0]  SC_downSPEEDTIMER_count_OutBUS,
    output logic [LEVELWIDTH-1:0] SC_downSPEEDTIMER_level_OutBUS
);
    logic clk, rst, lvl_fall, clr, tick, tick_n;
    state_t state, state_n;
    logic [DATAWIDTH-1:0] count, count_n, reload;
    logic [LEVELWIDTH-1:0] level, level_n;
    assign clk = SC_downSPEEDTIMER_CLOCK_50;
    assign rst = SC_downSPEEDTIMER_RESET_InHigh;
    sc_falledge_detect u_levelup (
        .clk  (clk),
        .rst  (rst),
        .sig  (SC_downSPEEDTIMER_levelup_InLow),
        .fall (lvl_fall)
    );
    assign reload = DATAWIDTH'(period(64'(BASE_PERIOD), 64'(STEP_PERIOD), 64'(MIN_PERIOD), 64'(level)) - 64'd1);
    assign clr = ~SC_downSPEEDTIMER_CLEAR_InLow && state != LOAD;
    // Leaving PAUSE with pause released counts on that same edge, so each paused edge costs one cycle.
    always_comb begin
        state_n = state;
        count_n = count;
        tick_n = 1'b0;
        if (state == IDLE) begin
            count_n = '0;
            state_n = SC_downSPEEDTIMER_start_InLow ? IDLE : LOAD;
        end else if (state == LOAD) begin
            count_n = reload;
            state_n = COUNT;
        end else if (clr) begin
            count_n = '0;
            state_n = IDLE;
        end else if (!SC_downSPEEDTIMER_pause_InLow) begin
            state_n = PAUSE;
        end else begin
            state_n = COUNT;
            tick_n = count == '0;
            count_n = (count == '0) ? reload : count - 1'b1;
        end
        level_n = clr ? '0 : (lvl_fall && level != '1) ? level + 1'b1 : level;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            level <= '0;
            tick <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            level <= level_n;
            tick <= tick_n;
        end
    end
    assign SC_downSPEEDTIMER_tick_Out = tick;
    assign SC_downSPEEDTIMER_running_Out = state == COUNT || state == PAUSE;
    assign SC_downSPEEDTIMER_count_OutBUS = count;
    assign SC_downSPEEDTIMER_level_OutBUS = level;
endmodule

// File: tb/tb_sc_downspeedtimer.sv
// tb_sc_downspeedtimer: scoreboard bench comparing the timer against a cycle model plus directed scenarios
module tb_sc_downspeedtimer;
    logic clk = 1'b0;
    logic rst, start, pause, levelup, clear;
    logic tick, running;
    logic [22:0] count;
    logic [1:0] level;
    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    int m_ph, m_cnt, m_lvl;
    bit m_tick, m_s, m_p;
    always #5 clk = ~clk;
    sc_downspeedtimer #(
        .DATAWIDTH(23), .LEVELWIDTH(2), .BASE_PERIOD(10), .STEP_PERIOD(2), .MIN_PERIOD(4)
    ) dut (
        .SC_downSPEEDTIMER_CLOCK_50     (clk),
        .SC_downSPEEDTIMER_RESET_InHigh (rst),
        .SC_downSPEEDTIMER_start_InLow  (start),
        .SC_downSPEEDTIMER_pause_InLow  (pause),
        .SC_downSPEEDTIMER_levelup_InLow(levelup),
        .SC_downSPEEDTIMER_CLEAR_InLow  (clear),
        .SC_downSPEEDTIMER_tick_Out     (tick),
        .SC_downSPEEDTIMER_running_Out  (running),
        .SC_downSPEEDTIMER_count_OutBUS (count),
        .SC_downSPEEDTIMER_level_OutBUS (level)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic int per(input int l);
        int p = 10 - 2 * l;
        return p < 4 ? 4 : p;
    endfunction
    function automatic void model(input bit r, st, pa, lu, cl);
        bit fall, clr_eff;
        if (r) begin
            m_ph = 0; m_cnt = 0; m_lvl = 0; m_tick = 0; m_s = 0; m_p = 0;
            return;
        end
        fall = m_p & ~m_s;
        clr_eff = !cl && m_ph != 1;
        m_tick = 0;
        case (m_ph)
            0: begin m_cnt = 0; if (!st) m_ph = 1; end
            1: begin m_cnt = per(m_lvl) - 1; m_ph = 2; end
            default: begin
                if (clr_eff) begin m_ph = 0; m_cnt = 0; end
                else if (!pa) m_ph = 3;
                else begin
                    m_ph = 2;
                    if (m_cnt == 0) begin m_tick = 1; m_cnt = per(m_lvl) - 1; end
                    else m_cnt--;
                end
            end
        endcase
        m_lvl = clr_eff ? 0 : (fall && m_lvl < 3) ? m_lvl + 1 : m_lvl;
        m_p = m_s;
        m_s = lu;
    endfunction
    task automatic cyc(input bit r, st, pa, lu, cl);
        rst = r; start = st; pause = pa; levelup = lu; clear = cl;
        model(r, st, pa, lu, cl);
        exp_q.push_back({5'b0, m_tick, m_ph >= 2, 2'(m_lvl), 23'(m_cnt)});
        @(posedge clk);
        #1;
        check("out", {5'b0, tick, running, level, count}, exp_q.pop_front());
    endtask
    task automatic idle();
        cyc(0, 1, 1, 1, 1);
    endtask
    task automatic wait_tick(output int n);
        n = 0;
        do begin idle(); n++; end while (!tick && n < 40);
    endtask
    task automatic wait_cnt(input int v, output int n);
        n = 0;
        do begin idle(); n++; end while (count != 23'(v) && n < 40);
    endtask
    initial begin
        int n;
        cyc(1, 1, 1, 1, 1);
        cyc(1, 1, 1, 1, 1);
        check("rst_out", {tick, running, level, count}, '0);
        cyc(0, 0, 1, 1, 1);
        check("load_running", running, 0);
        idle();
        check("start_count", count, 9);
        check("start_running", running, 1);
        wait_tick(n);
        check("first_tick", n, 10);
        check("tick_count", count, 9);
        wait_tick(n);
        check("gap_l0", n, 10);
        cyc(0, 1, 1, 0, 1);
        check("lvl_pre", level, 0);
        idle();
        check("lvl_post", level, 1);
        wait_tick(n);
        check("gap_cur_period", n + 2, 10);
        wait_tick(n);
        check("gap_l1", n, 8);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 1, 0, 1);
            idle();
        end
        check("lvl_sat", level, 3);
        wait_tick(n);
        wait_tick(n);
        check("gap_floor", n, 4);
        cyc(0, 1, 1, 1, 0);
        check("clear_out", {tick, running, level, count}, '0);
        cyc(0, 0, 1, 1, 1);
        idle();
        wait_cnt(5, n);
        check("to_five", n, 4);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 1, 1);
            check("pause_hold", count, 5);
        end
        wait_tick(n);
        check("gap_pause", 7 + n, 13);
        wait_tick(n);
        check("gap_after_pause", n, 10);
        cyc(0, 1, 1, 0, 1);
        idle();
        check("lvl_before_prio", level, 1);
        wait_cnt(0, n);
        cyc(0, 1, 0, 1, 0);
        check("prio_out", {tick, running, level, count}, '0);
        cyc(0, 1, 1, 0, 1);
        cyc(0, 1, 1, 1, 0);
        check("clr_vs_lvl", level, 0);
        idle();
        check("clr_vs_lvl_after", level, 0);
        cyc(0, 1, 1, 0, 1);
        idle();
        check("lvl_idle", level, 1);
        cyc(0, 1, 1, 0, 1);
        idle();
        cyc(0, 0, 1, 1, 1);
        idle();
        idle(); idle(); idle();
        check("l2_count", count, 2);
        cyc(1, 0, 1, 1, 1);
        check("rst_mid_out", {tick, running, level, count}, '0);
        cyc(1, 0, 1, 1, 1);
        cyc(0, 0, 1, 1, 1);
        check("post_rst_load", {running, count}, '0);
        cyc(0, 1, 1, 1, 1);
        check("post_rst_count", count, 9);
        for (int i = 0; i < 400; i++)
            cyc(0, $urandom_range(3) != 0, $urandom_range(5) != 0, $urandom_range(7) != 0, $urandom_range(39) != 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
